// File: rtl/ppu_frame_timing.sv
`default_nettype none
// ============================================================================
// Module      : ppu_frame_timing
// Description : NTSC PPU raster timing. Generates the dot/scanline position
//               (with the odd-frame dot skip), the vblank status flag with
//               its $2002 read race, the NMI request and frame-phase strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_frame_timing #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VISIBLE_LINES   = 240,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rendering_en_i,
    input  logic       nmi_en_i,
    input  logic       status_rd_i,
    output logic [8:0] x_pos_o,
    output logic [8:0] y_pos_o,
    output logic       vblank_o,
    output logic       nmi_o,
    output logic       frame_odd_o,
    output logic       visible_o,
    output logic       prerender_o,
    output logic       frame_start_o
);

    // Raster landmarks, sized to the 9-bit position counters.
    localparam logic [8:0] c_last_dot       = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_skip_dot       = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] c_last_line      = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] c_visible_lines  = 9'(VISIBLE_LINES);
    localparam logic [8:0] c_vblank_line    = 9'(VBLANK_LINE);
    localparam logic [8:0] c_prerender_line = 9'(PRERENDER_LINE);
    localparam logic [8:0] c_flag_dot       = 9'd1;

    logic [8:0] r_x;
    logic [8:0] r_y;
    logic       r_vblank;
    logic       r_frame_odd;
    logic       r_suppress;

    logic w_line_end;
    logic w_frame_end;
    logic w_skip;
    logic w_wrap;
    logic w_set_dot;
    logic w_clr_dot;
    logic w_race;

    // Position decodes that steer the counters.
    assign w_line_end  = (r_x == c_last_dot);
    assign w_frame_end = w_line_end && (r_y == c_last_line);

    // Odd frames with rendering on drop the last dot of the pre-render line;
    // rendering_en_i is looked at only on this one dot.
    assign w_skip = (r_y == c_prerender_line) && (r_x == c_skip_dot)
                    && r_frame_odd && rendering_en_i;

    // Either way of finishing a frame lands on (0,0).
    assign w_wrap = w_frame_end || w_skip;

    // The flag sets on the edge leaving dot 1 of the vblank line and clears on
    // the edge leaving dot 1 of the pre-render line.
    assign w_set_dot = (r_y == c_vblank_line)    && (r_x == c_flag_dot);
    assign w_clr_dot = (r_y == c_prerender_line) && (r_x == c_flag_dot);

    // A status read just before the flag would set cancels this frame's flag.
    assign w_race = status_rd_i && (r_y == c_vblank_line)
                    && ((r_x == 9'd0) || (r_x == c_flag_dot));

    // Dot and scanline counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_x <= 9'd0;
            r_y <= 9'd0;
        end else if (w_wrap) begin
            r_x <= 9'd0;
            r_y <= 9'd0;
        end else if (w_line_end) begin
            r_x <= 9'd0;
            r_y <= r_y + 9'd1;
        end else begin
            r_x <= r_x + 9'd1;
        end
    end

    // Frame parity flips on every entry to (0,0), skipped frame or not.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_frame_odd <= 1'b0;
        end else if (w_wrap) begin
            r_frame_odd <= ~r_frame_odd;
        end
    end

    // Suppress latch: armed by a racing read, released at the flag-clear dot.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_suppress <= 1'b0;
        end else if (w_clr_dot) begin
            r_suppress <= 1'b0;
        end else if (w_race) begin
            r_suppress <= 1'b1;
        end
    end

    // Vblank flag: a status read always wins, then the clear, then the set.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vblank <= 1'b0;
        end else if (status_rd_i || w_clr_dot) begin
            r_vblank <= 1'b0;
        end else if (w_set_dot && !r_suppress) begin
            r_vblank <= 1'b1;
        end
    end

    // Outputs come straight from the registers or from simple decodes of them;
    // nmi_o follows nmi_en_i combinationally so an enable during vblank
    // raises a fresh NMI edge at once.
    assign x_pos_o       = r_x;
    assign y_pos_o       = r_y;
    assign vblank_o      = r_vblank;
    assign nmi_o         = r_vblank && nmi_en_i;
    assign frame_odd_o   = r_frame_odd;
    assign visible_o     = (r_y < c_visible_lines);
    assign prerender_o   = (r_y == c_prerender_line);
    assign frame_start_o = (r_x == 9'd0) && (r_y == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_ppu_frame_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_frame_timing
// Description : Self-checking bench for ppu_frame_timing. A reduced raster
//               instance carries the frame-level scenarios and a randomized
//               run against a frame-index reference model; a full-size NTSC
//               instance checks the first line boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_frame_timing;

    // Reduced raster geometry for the main instance.
    localparam int D   = 24;   // dots per line
    localparam int L   = 20;   // lines per frame
    localparam int VIS = 12;   // visible lines
    localparam int V   = 13;   // vblank line
    localparam int P   = 19;   // pre-render line

    logic clk;
    logic rst_n;
    logic ren;
    logic nmi_en;
    logic rd;

    logic [8:0] x, y;
    logic       vb, nmi, odd, vis, pre, fs;
    logic [8:0] f_x, f_y;
    logic       f_vb, f_nmi, f_odd, f_vis, f_pre, f_fs;

    int n_checks = 0;
    int n_fail   = 0;

    ppu_frame_timing #(
        .DOTS_PER_LINE  (D),
        .LINES_PER_FRAME(L),
        .VISIBLE_LINES  (VIS),
        .VBLANK_LINE    (V),
        .PRERENDER_LINE (P)
    ) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rendering_en_i(ren),
        .nmi_en_i      (nmi_en),
        .status_rd_i   (rd),
        .x_pos_o       (x),
        .y_pos_o       (y),
        .vblank_o      (vb),
        .nmi_o         (nmi),
        .frame_odd_o   (odd),
        .visible_o     (vis),
        .prerender_o   (pre),
        .frame_start_o (fs)
    );

    ppu_frame_timing u_dut_full (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rendering_en_i(ren),
        .nmi_en_i      (nmi_en),
        .status_rd_i   (rd),
        .x_pos_o       (f_x),
        .y_pos_o       (f_y),
        .vblank_o      (f_vb),
        .nmi_o         (f_nmi),
        .frame_odd_o   (f_odd),
        .visible_o     (f_vis),
        .prerender_o   (f_pre),
        .frame_start_o (f_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position is a dot index into the current frame; the
    // flag is driven by the set / clear / read events at fixed frame indices.
    int   m_t;
    logic m_odd, m_vb, m_sup;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t   <= 0;
            m_odd <= 1'b0;
            m_vb  <= 1'b0;
            m_sup <= 1'b0;
        end else begin
            if ((m_t == P * D + D - 2 && m_odd && ren) || m_t == D * L - 1) begin
                m_t   <= 0;
                m_odd <= !m_odd;
            end else begin
                m_t <= m_t + 1;
            end
            if (rd || m_t == P * D + 1)
                m_vb <= 1'b0;
            else if (m_t == V * D + 1 && !m_sup)
                m_vb <= 1'b1;
            if (m_t == P * D + 1)
                m_sup <= 1'b0;
            else if (rd && (m_t == V * D || m_t == V * D + 1))
                m_sup <= 1'b1;
        end
    end

    task automatic step;
        @(negedge clk);
    endtask

    // Advance to the next cycle showing (wx,wy) on the reduced instance.
    task automatic wait_pos(input int wx, input int wy);
        int budget;
        budget = 2 * D * L + 4;
        while ((x != 9'(wx) || y != 9'(wy)) && budget > 0) begin
            step();
            budget--;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL wait_pos timeout: at (%0d,%0d), wanted (%0d,%0d)", x, y, wx, wy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ren = 1'b0; nmi_en = 1'b0; rd = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({x, y, vb, nmi, odd, vis, pre, fs} !== {9'd0, 9'd0, 6'b000101}) begin
            n_fail++;
            $display("FAIL reset_hold got x=%0d y=%0d flags=%b want 0 0 000101", x, y, {vb, nmi, odd, vis, pre, fs});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({x, y, vb, nmi, odd, vis, pre, fs} !== {9'd0, 9'd0, 6'b000101}) begin
            n_fail++;
            $display("FAIL reset_release got x=%0d y=%0d flags=%b want 0 0 000101", x, y, {vb, nmi, odd, vis, pre, fs});
        end
        n_checks++;
        if ({f_x, f_y, f_vb, f_nmi, f_odd, f_vis, f_pre, f_fs} !== {9'd0, 9'd0, 6'b000101}) begin
            n_fail++;
            $display("FAIL reset_full got x=%0d y=%0d flags=%b want 0 0 000101", f_x, f_y, {f_vb, f_nmi, f_odd, f_vis, f_pre, f_fs});
        end
    endtask

    task automatic test_full_size;
        repeat (340) step();
        n_checks++;
        if (f_x !== 9'd340 || f_y !== 9'd0 || f_fs !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dot340 got (%0d,%0d) fs=%b want (340,0) fs=0", f_x, f_y, f_fs);
        end
        step();
        n_checks++;
        if (f_x !== 9'd0 || f_y !== 9'd1 || f_fs !== 1'b0 || f_vis !== 1'b1) begin
            n_fail++;
            $display("FAIL full_line1 got (%0d,%0d) fs=%b vis=%b want (0,1) fs=0 vis=1", f_x, f_y, f_fs, f_vis);
        end
    endtask

    task automatic test_frame_length;
        int n;
        ren = 1'b0;
        wait_pos(0, 0);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!fs && n < 2 * D * L);
            n_checks++;
            if (n != D * L) begin
                n_fail++;
                $display("FAIL frame_len[%0d] got %0d want %0d", f, n, D * L);
            end
        end
    endtask

    task automatic test_odd_skip;
        int n, px, py, want_len, want_x;
        rst_n = 1'b0;
        step();
        ren   = 1'b1;
        rst_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            n_checks++;
            if (odd !== 1'(f % 2)) begin
                n_fail++;
                $display("FAIL odd_parity[%0d] got %b want %0d", f, odd, f % 2);
            end
            n = 0; px = 0; py = 0;
            do begin
                px = int'(x); py = int'(y);
                step();
                n++;
            end while (!fs && n < 2 * D * L);
            want_len = (f % 2 == 1) ? D * L - 1 : D * L;
            want_x   = (f % 2 == 1) ? D - 2 : D - 1;
            n_checks++;
            if (n != want_len) begin
                n_fail++;
                $display("FAIL odd_len[%0d] got %0d want %0d", f, n, want_len);
            end
            n_checks++;
            if (px != want_x || py != P) begin
                n_fail++;
                $display("FAIL odd_last_dot[%0d] got (%0d,%0d) want (%0d,%0d)", f, px, py, want_x, P);
            end
        end
        ren = 1'b0;
    endtask

    task automatic test_vblank_nmi;
        int n;
        nmi_en = 1'b1;
        wait_pos(1, V);
        n_checks++;
        if (vb !== 1'b0 || nmi !== 1'b0) begin
            n_fail++;
            $display("FAIL vb_before_set got vb=%b nmi=%b want 0 0", vb, nmi);
        end
        step();
        n_checks++;
        if (vb !== 1'b1 || nmi !== 1'b1) begin
            n_fail++;
            $display("FAIL vb_rise got vb=%b nmi=%b at (%0d,%0d) want 1 1", vb, nmi, x, y);
        end
        n = 0;
        while (vb === 1'b1 && n < 2 * D * L) begin
            step();
            n++;
        end
        n_checks++;
        if (n != (P - V) * D) begin
            n_fail++;
            $display("FAIL vb_width got %0d want %0d", n, (P - V) * D);
        end
        n_checks++;
        if (x !== 9'd2 || y !== 9'(P) || nmi !== 1'b0) begin
            n_fail++;
            $display("FAIL vb_fall got (%0d,%0d) nmi=%b want (2,%0d) nmi=0", x, y, nmi, P);
        end
    endtask

    task automatic test_race(input int xr);
        logic seen_high;
        int   budget;
        nmi_en = 1'b1;
        wait_pos(xr, V);
        n_checks++;
        if (vb !== ((xr >= 2) ? 1'b1 : 1'b0)) begin
            n_fail++;
            $display("FAIL race%0d_read_value got %b want %b", xr, vb, (xr >= 2));
        end
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (xr >= 2) begin
            n_checks++;
            if (vb !== 1'b0 || x !== 9'(xr + 1)) begin
                n_fail++;
                $display("FAIL race%0d_after_read got vb=%b x=%0d want 0 %0d", xr, vb, x, xr + 1);
            end
        end
        seen_high = vb | nmi;
        budget = 2 * D * L;
        while ((x != 9'(D - 1) || y != 9'(P - 1)) && budget > 0) begin
            step();
            budget--;
            seen_high = seen_high | vb | nmi;
        end
        n_checks++;
        if (seen_high !== 1'b0 || budget == 0) begin
            n_fail++;
            $display("FAIL race%0d_hold got seen_high=%b budget=%0d want 0 and nonzero", xr, seen_high, budget);
        end
    endtask

    task automatic test_nmi_enable;
        nmi_en = 1'b1;
        wait_pos(9, V + 4);
        n_checks++;
        if (nmi !== 1'b1 || vb !== 1'b1) begin
            n_fail++;
            $display("FAIL nmi_en_on got nmi=%b vb=%b want 1 1", nmi, vb);
        end
        nmi_en = 1'b0;
        step();
        n_checks++;
        if (nmi !== 1'b0 || vb !== 1'b1 || x !== 9'd10) begin
            n_fail++;
            $display("FAIL nmi_en_off got nmi=%b vb=%b x=%0d want 0 1 10", nmi, vb, x);
        end
        wait_pos(19, V + 4);
        n_checks++;
        if (nmi !== 1'b0) begin
            n_fail++;
            $display("FAIL nmi_en_stay_off got nmi=%b want 0", nmi);
        end
        nmi_en = 1'b1;
        step();
        n_checks++;
        if (nmi !== 1'b1 || x !== 9'd20) begin
            n_fail++;
            $display("FAIL nmi_en_again got nmi=%b x=%0d want 1 20", nmi, x);
        end
    endtask

    task automatic test_reset_midframe;
        wait_pos(15, V);
        n_checks++;
        if (vb !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_vb got %b want 1", vb);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x, y, vb, nmi, odd, vis, pre, fs} !== {9'd0, 9'd0, 6'b000101}) begin
            n_fail++;
            $display("FAIL midreset_immediate got x=%0d y=%0d flags=%b want 0 0 000101", x, y, {vb, nmi, odd, vis, pre, fs});
        end
        step();
        rst_n = 1'b1;
        repeat (5) step();
        n_checks++;
        if (x !== 9'd5 || y !== 9'd0 || odd !== 1'b0 || vb !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart got (%0d,%0d) odd=%b vb=%b want (5,0) 0 0", x, y, odd, vb);
        end
    endtask

    task automatic test_random;
        logic [23:0] got_v, exp_v;
        logic        near;
        for (int i = 0; i < 8 * D * L; i++) begin
            got_v = {x, y, vb, nmi, odd, vis, pre, fs};
            exp_v = {9'(m_t % D), 9'(m_t / D), m_vb, m_vb & nmi_en, m_odd,
                     (m_t / D) < VIS, (m_t / D) == P, m_t == 0};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", i, got_v, exp_v);
            end
            ren  = ($urandom_range(7) != 0);
            near = (m_t >= V * D && m_t <= V * D + 2);
            rd   = near ? ($urandom_range(2) == 0) : ($urandom_range(40) == 0);
            if ($urandom_range(15) == 0) nmi_en = !nmi_en;
            step();
        end
        rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_size();
        test_frame_length();
        test_odd_skip();
        test_vblank_nmi();
        test_race(1);
        test_race(0);
        test_race(2);
        test_nmi_enable();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
